// File: rtl/video_fill_engine_if.sv
// Request and pixel-write signals between the fill engine and its neighbours.
// master: the fill engine (takes the request, drives the write bus).
// slave: the requester / video-controller side.
interface video_fill_engine_if #(
   parameter int SCREEN_WIDTH_BIT_WIDTH  = 8,
   parameter int SCREEN_HEIGHT_BIT_WIDTH = 8
);
   logic                                                start;
   logic [SCREEN_WIDTH_BIT_WIDTH-1:0]                   x0;
   logic [SCREEN_HEIGHT_BIT_WIDTH-1:0]                  y0;
   logic [SCREEN_WIDTH_BIT_WIDTH:0]                     width;
   logic [SCREEN_HEIGHT_BIT_WIDTH:0]                    height;
   logic [23:0]                                         color;
   logic                                                write_ready;
   logic                                                write;
   logic [SCREEN_WIDTH_BIT_WIDTH+SCREEN_HEIGHT_BIT_WIDTH-1:0] address;
   logic [31:0]                                         data;
   logic                                                busy;
   logic                                                done;

   modport master (
      input  start, x0, y0, width, height, color, write_ready,
      output write, address, data, busy, done
   );

   modport slave (
      output start, x0, y0, width, height, color, write_ready,
      input  write, address, data, busy, done
   );
endinterface

// File: rtl/video_fill_engine.sv
// Rectangle fill: one pixel write per accepted cycle, raster order, clipped to the screen.
// Latency: start edge T -> CLIP, first write sampled at edge T+2, done one cycle after last write.
// Backpressure: write_ready low holds write/address/data; each stalled cycle adds one cycle.
module video_fill_engine #(
   parameter int SCREEN_WIDTH_BIT_WIDTH  = 8,
   parameter int SCREEN_HEIGHT_BIT_WIDTH = 8
) (
   input logic                 clock,
   input logic                 reset,
   video_fill_engine_if.master bus
);
   localparam int XW = SCREEN_WIDTH_BIT_WIDTH;
   localparam int YW = SCREEN_HEIGHT_BIT_WIDTH;

   localparam logic [XW:0]   SCREEN_W = {1'b1, {XW{1'b0}}};
   localparam logic [YW:0]   SCREEN_H = {1'b1, {YW{1'b0}}};
   localparam logic [XW-1:0] X_ONE    = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [YW-1:0] Y_ONE    = {{(YW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x0_q, x0_d, x_q, x_d, x_last_q, x_last_d;
   logic [YW-1:0] y0_q, y0_d, y_q, y_d, y_last_q, y_last_d;
   logic [XW:0]   width_q, width_d;
   logic [YW:0]   height_q, height_d;
   logic [23:0]   color_q, color_d;

   logic [XW:0]   room_x, eff_w;
   logic [YW:0]   room_y, eff_h;

   // Clipped extent: the space left to the screen edge can never underflow.
   always_comb begin
      room_x = SCREEN_W - {1'b0, x0_q};
      room_y = SCREEN_H - {1'b0, y0_q};
      eff_w  = (width_q  < room_x) ? width_q  : room_x;
      eff_h  = (height_q < room_y) ? height_q : room_y;
   end

   // State register and latched request/counters; reset aborts any fill.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         width_q  <= '0;
         height_q <= '0;
         color_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         x_last_q <= '0;
         y_last_q <= '0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         width_q  <= width_d;
         height_q <= height_d;
         color_q  <= color_d;
         x_q      <= x_d;
         y_q      <= y_d;
         x_last_q <= x_last_d;
         y_last_q <= y_last_d;
      end
   end

   // Next state: latch in IDLE, clip, walk the rectangle on accepted writes.
   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      width_d  = width_q;
      height_d = height_q;
      color_d  = color_q;
      x_d      = x_q;
      y_d      = y_q;
      x_last_d = x_last_q;
      y_last_d = y_last_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               x0_d     = bus.x0;
               y0_d     = bus.y0;
               width_d  = bus.width;
               height_d = bus.height;
               color_d  = bus.color;
               state_d  = CLIP;
            end
         end
         CLIP: begin
            if (eff_w == '0 || eff_h == '0) begin
               state_d = DONE;
            end else begin
               x_d      = x0_q;
               y_d      = y0_q;
               // A full-width extent truncates to 0 here; the modular add still lands on the last column.
               x_last_d = x0_q + eff_w[XW-1:0] - X_ONE;
               y_last_d = y0_q + eff_h[YW-1:0] - Y_ONE;
               state_d  = FILL;
            end
         end
         FILL: begin
            if (bus.write_ready) begin
               if (x_q != x_last_q) begin
                  x_d = x_q + X_ONE;
               end else if (y_q != y_last_q) begin
                  x_d = x0_q;
                  y_d = y_q + Y_ONE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.write   = (state_q == FILL);
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.address = {y_q, x_q};
   assign bus.data    = {8'h00, color_q};
endmodule
